// File: rtl/fir_decim_buf.sv
// rtl/fir_decim_buf.sv - decimate the fir output stream by M and buffer it in a ready/valid FIFO
// Optional feature macro: FIR_DECIM_AVG_EN (boxcar average instead of pick-every-Mth)
module fir_decim_buf #(
  parameter int S     = 16,
  parameter int M     = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [S-1:0]             din,
  input  logic                     din_vld,
  output logic [S-1:0]             dout,
  output logic                     dout_vld,
  input  logic                     dout_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int PW = $clog2(M);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PW-1:0] ph;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [S-1:0]  mem [DEPTH];
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic [S-1:0]  push_data;

  // A push is the last sample of each group of M; a full FIFO still takes it if a pop frees a slot
  assign push  = din_vld && (ph == PW'(M - 1));
  assign pop   = dout_vld && dout_rdy;
  assign full  = (level == LW'(DEPTH));
  assign wr_en = push && (!full || pop);

  // Phase counter: counts valid samples within the current decimation group
  always_ff @(posedge clk) begin
    if (rst) begin
      ph <= '0;
    end else if (din_vld) begin
      ph <= (ph == PW'(M - 1)) ? '0 : ph + PW'(1);
    end
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int XW = S + PW;

  logic signed [XW-1:0] acc;
  logic signed [XW-1:0] sum;

  // Sum includes the current sample so the group average is ready on the push cycle
  assign sum       = acc + {{PW{din[S-1]}}, din};
  assign push_data = S'(sum >>> PW);

  // Accumulator: restarts from zero right after each group is emitted
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (push) begin
      acc <= '0;
    end else if (din_vld) begin
      acc <= sum;
    end
  end
`else
  assign push_data = din;
`endif

  // Storage array: no reset needed, occupancy tracking decides what is valid
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, sticky overflow and the registered head sample
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      if (wr_en && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !wr_en) begin
        level <= level - LW'(1);
      end

      if (push && full && !pop) begin
        ovf <= 1'b1;
      end

      // Next head comes from memory if more entries remain, else from the sample being written.
      // When full with push+pop, wr_ptr==rd_ptr so the write lands on the old head, not rd_ptr+1.
      if (pop) begin
        if (level > LW'(1)) begin
          dout     <= mem[rd_ptr + AW'(1)];
          dout_vld <= 1'b1;
        end else if (wr_en) begin
          dout     <= push_data;
          dout_vld <= 1'b1;
        end else begin
          dout_vld <= 1'b0;
        end
      end else if ((level == '0) && wr_en) begin
        dout     <= push_data;
        dout_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_decim_buf.sv
// tb/tb_fir_decim_buf.sv - scoreboard bench for fir_decim_buf (M=4, DEPTH=8)
module tb_fir_decim_buf;

  localparam int S     = 16;
  localparam int M     = 4;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

`ifdef FIR_DECIM_AVG_EN
  localparam int E2A = 16'h0002;
  localparam int E2B = 16'h0006;
  localparam int E6  = 16'h0011;
  localparam int GOFS = 2;
`else
  localparam int E2A = 16'h0004;
  localparam int E2B = 16'h0008;
  localparam int E6  = 16'h0013;
  localparam int GOFS = 4;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [S-1:0]  din;
  logic          din_vld;
  logic [S-1:0]  dout;
  logic          dout_vld;
  logic          dout_rdy;
  logic [LW-1:0] level;
  logic          ovf;

  always #5 clk = ~clk;

  fir_decim_buf #(.S(S), .M(M), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .level    (level),
    .ovf      (ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [S-1:0] exp_q[$];
  logic [S-1:0] got_q[$];
  int           m_ph  = 0;
  int           m_acc = 0;
  bit           m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: predict this edge from the reference model, clock, then compare
  task automatic cycle();
    bit           pop;
    bit           push;
    bit           full;
    logic [S-1:0] pv;
    int           sum;
    pop  = 1'b0;
    push = 1'b0;
    pv   = '0;
    if (rst) begin
      exp_q.delete();
      m_ph  = 0;
      m_acc = 0;
      m_ovf = 1'b0;
    end else begin
      check("dout_vld", 32'(dout_vld), 32'(exp_q.size() != 0));
      full = (exp_q.size() == DEPTH);
      if (exp_q.size() != 0 && dout_rdy) begin
        check("dout", 32'(dout), 32'(exp_q[0]));
        got_q.push_back(dout);
        pop = 1'b1;
      end
      if (din_vld) begin
`ifdef FIR_DECIM_AVG_EN
        sum = m_acc + int'($signed(din));
        if (m_ph == M - 1) begin
          push  = 1'b1;
          pv    = S'(sum >>> $clog2(M));
          m_acc = 0;
        end else begin
          m_acc = sum;
        end
`else
        sum = 0;
        if (m_ph == M - 1) begin
          push = 1'b1;
          pv   = din;
        end
`endif
        m_ph = (m_ph + 1) % M;
      end
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        if (!full || pop) exp_q.push_back(pv);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("level", 32'(level), 32'(exp_q.size()));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic feed(input logic [S-1:0] v, input logic rdy);
    din      = v;
    din_vld  = 1'b1;
    dout_rdy = rdy;
    cycle();
    din_vld  = 1'b0;
  endtask

  task automatic drain();
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle();
    check("drain_done", 32'(exp_q.size()), 32'd0);
    dout_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    din_vld = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    got_q.delete();
  endtask

  initial begin
    rst      = 1'b1;
    din      = '0;
    din_vld  = 1'b0;
    dout_rdy = 1'b0;

    // 1: reset held with din_vld high
    din     = 16'h1234;
    din_vld = 1'b1;
    repeat (3) cycle();
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_vld", 32'(dout_vld), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    rst     = 1'b0;
    din_vld = 1'b0;
    got_q.delete();
    cycle();

    // 2: decimation 1..8 with consumer always ready
    for (int i = 1; i <= 4; i++) feed(S'(i), 1'b1);
    check("t2_first_vld", 32'(dout_vld), 32'h1);
    check("t2_first_val", 32'(dout), 32'(E2A));
    for (int i = 5; i <= 8; i++) feed(S'(i), 1'b1);
    drain();
    check("t2_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("t2_out0", 32'(got_q[0]), 32'(E2A));
      check("t2_out1", 32'(got_q[1]), 32'(E2B));
    end

    // 3: negative rounding
    do_reset();
    feed(16'hFFFF, 1'b1);
    feed(16'hFFFF, 1'b1);
    feed(16'hFFFF, 1'b1);
    feed(16'hFFFE, 1'b1);
    drain();
    check("t3_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("t3_out", 32'(got_q[0]), 32'h0000FFFE);

    // 4: overflow with stalled consumer
    do_reset();
    for (int i = 1; i <= 36; i++) feed(S'(i), 1'b0);
    check("t4_level", 32'(level), 32'd8);
    check("t4_ovf", 32'(ovf), 32'd1);
    drain();
    check("t4_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < got_q.size() && i < 8; i++)
      check("t4_out", 32'(got_q[i]), 32'(4 * i + GOFS));
    check("t4_ovf_sticky", 32'(ovf), 32'd1);

    // 5: full FIFO with push and pop in the same cycle
    do_reset();
    for (int i = 1; i <= 35; i++) feed(S'(i), 1'b0);
    feed(16'd36, 1'b1);
    dout_rdy = 1'b0;
    check("t5_level", 32'(level), 32'd8);
    check("t5_ovf", 32'(ovf), 32'd0);
    check("t5_head", 32'(dout), 32'(4 + GOFS));
    drain();
    check("t5_count", 32'(got_q.size()), 32'd9);
    if (got_q.size() == 9) check("t5_last", 32'(got_q[8]), 32'(32 + GOFS));

    // 6: reset in the middle of a group
    do_reset();
    feed(16'h0005, 1'b1);
    feed(16'h0006, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    got_q.delete();
    for (int i = 16; i <= 19; i++) feed(S'(i), 1'b1);
    drain();
    check("t6_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("t6_out", 32'(got_q[0]), 32'(E6));

    // random traffic with sparse input and a bursty consumer
    do_reset();
    for (int i = 0; i < 400; i++) begin
      din      = S'($urandom);
      din_vld  = ($urandom_range(0, 1) == 1);
      dout_rdy = ($urandom_range(0, 3) == 0);
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
